if_id_queue: RTL and testbench

- Instruction queue between the fetch/I-cache stage and the decode stage. Acts as the IF/ID boundary register, with buffering.
- Decouples I-cache hit/miss timing from decode stalls caused by the hazard unit.
- Drops all wrong-path instructions on a branch-mispredict flush.
- Feeds decode the instruction word, its PC, the branch-prediction bit, and the 16-bit immediate field consumed by the sign extender.

---
 rtl/if_id_queue.sv | 108 ++++++++++
 tb/tb_if_id_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: instruction queue at the IF/ID boundary.
// It buffers fetched instructions so that I-cache timing is decoupled from
// decode stalls. It works as a first-word fall-through FIFO with no
// input-to-output bypass. A flush drops every queued (wrong-path) entry.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drop all entries; has priority over push and pop
//   in_valid/ready   fetch handshake; in_ready = not full
//   in_instr/pc/pred_taken  fetched instruction, its PC, predictor bit
//   out_valid/ready  decode handshake; out_valid = not empty
//   out_instr/pc/pc_plus4/pred_taken/imm16  head entry; zero/NOP when empty
//   count            number of valid entries, 0..DEPTH
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic             out_pred_taken,
  output logic [15:0]      out_imm16,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = (PTR_W)'(1);

  // Each entry holds {pred_taken, pc, instr}.
  logic [64:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic        push, pop;
  logic [64:0] head;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush masks both handshakes, so the pointers never move in a flush cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= {in_pred_taken, in_pc, in_instr};
    end
  end

  // Stale array contents are masked while empty so decode sees a clean bubble.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (out_valid) begin
      out_instr      = head[31:0];
      out_pc         = head[63:32];
      out_pc_plus4   = head[63:32] + 32'd4;
      out_pred_taken = head[64];
    end else begin
      out_instr      = '0;
      out_pc         = '0;
      out_pc_plus4   = '0;
      out_pred_taken = 1'b0;
    end
  end

  assign out_imm16 = out_instr[15:0];

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_pred_taken;
  logic [15:0] out_imm16;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  if_id_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_pred_taken(out_pred_taken), .out_imm16(out_imm16), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_pc_plus4 !== 32'h0) begin fails++; $display("FAIL reset_pc_plus4 got %h exp 0", out_pc_plus4); end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2008_FFFC; in_pc = 32'h0040_0000; in_pred_taken = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_imm16 !== 16'hFFFC) begin fails++; $display("FAIL single_imm16 got %h exp fffc", out_imm16); end
    checks++; if (out_pc_plus4 !== 32'h0040_0004) begin fails++; $display("FAIL single_pc_plus4 got %h exp 00400004", out_pc_plus4); end
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (out_instr !== 32'h2008_FFFC) begin fails++; $display("FAIL single_instr got %h exp 2008fffc", out_instr); end
    checks++; if (out_pred_taken !== 1'b1) begin fails++; $display("FAIL single_pred got %0b exp 1", out_pred_taken); end
    // Held stable under stall
    step();
    checks++; if (out_pc !== 32'h0040_0000) begin fails++; $display("FAIL single_stall_pc got %h exp 00400000", out_pc); end
    flush = 1'b1; step(); flush = 1'b0;
    in_pred_taken = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA000_0000 | 32'(4 * i);
      step();
    end
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
    in_valid = 1'b1; in_pc = 32'd16; in_instr = 32'hA000_0010;
    step();
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_5th_count got %0d exp 4", count); end
    checks++; if (out_pc !== 32'd0) begin fails++; $display("FAIL fill_head_pc got %h exp 0", out_pc); end
    checks++; if (out_instr !== 32'hA000_0000) begin fails++; $display("FAIL fill_head_instr got %h exp a0000000", out_instr); end
  endtask

  task automatic test_full_pop();
    // pc=16 still presented from the fill test
    out_ready = 1'b1;
    step();
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL fullpop_count got %0d exp 3", count); end
    checks++; if (out_pc !== 32'd4) begin fails++; $display("FAIL fullpop_head got %h exp 4", out_pc); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fullpop_in_ready got %0b exp 1", in_ready); end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL fullpop_accept_count got %0d exp 4", count); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_pc !== 32'(4 * i)) begin fails++; $display("FAIL drain_pc[%0d] got %h exp %h", i, out_pc, 32'(4 * i)); end
      step();
    end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL drain_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid got %0b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hB000_0000 | 32'(i);
      step();
      checks++; if (out_pc !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 32'(4 * i)); end
      checks++; if (count !== 3'd1) begin fails++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL stream_end_count got %0d exp 0", count); end
  endtask

  task automatic test_pc_wrap();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_instr = 32'h1234_8765;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc_plus4 !== 32'h0) begin fails++; $display("FAIL pcwrap_plus4 got %h exp 0", out_pc_plus4); end
    checks++; if (out_imm16 !== 16'h8765) begin fails++; $display("FAIL pcwrap_imm16 got %h exp 8765", out_imm16); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_instr = 32'hC000_0000 | 32'(i);
      step();
    end
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hDEAD_0100;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL flush_out_instr got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL flush_out_pc got %h exp 0", out_pc); end
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hE000_0300;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h300) begin fails++; $display("FAIL flush_next_pc got %h exp 300", out_pc); end
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL flush_next_count got %0d exp 1", count); end
  endtask

  task automatic test_async_reset();
    // one entry (pc 0x300) queued from the flush test; add one more
    in_valid = 1'b1; in_pc = 32'h304; in_instr = 32'hE000_0304;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin fails++; $display("FAIL areset_pre_count got %0d exp 2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL areset_out_instr got %h exp 0", out_instr); end
    checks++; if (out_pc_plus4 !== 32'h0) begin fails++; $display("FAIL areset_plus4 got %h exp 0", out_pc_plus4); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL areset_count got %0d exp 0", count); end
    #3 rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'hF000_0400;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h400) begin fails++; $display("FAIL areset_after_pc got %h exp 400", out_pc); end
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL areset_after_count got %0d exp 1", count); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_pc_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
